// File: rtl/ifu_fetch_stage_pkg.sv
// Shared constants, state encoding and fetch-buffer entry layout for the fetch stage.
package ifu_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    localparam logic [3:0] MCAUSE_INSN_MISALIGNED   = 4'd0;
    localparam logic [3:0] MCAUSE_INSN_ACCESS_FAULT = 4'd1;

    // Major opcodes, bits [6:2] of the instruction word
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [3:0]  mcause;
    } fetch_entry_t;

    // Build a buffer entry from a memory response; faulting fetches become a NOP carrying the fault.
    function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                                input logic [31:0] rdata,
                                                input logic        err);
        fetch_entry_t e;
        e.pc     = pc;
        e.inst   = err ? NOP_INST : rdata;
        e.exc    = err;
        e.mcause = err ? MCAUSE_INSN_ACCESS_FAULT : MCAUSE_INSN_MISALIGNED;
        return e;
    endfunction

endpackage

// File: rtl/ifu_fetch_stage_fifo.sv
// Small circular buffer for fetched entries; clear empties it in one cycle.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_count = count_q;
    assign o_rdata = mem_q[rptr_q];

    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);

    // Storage array; contents need no reset since empty entries are never presented.
    always_ff @(posedge i_clock) begin
        if (do_push && !i_clear) mem_q[wptr_q] <= i_wdata;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (i_clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu_fetch_stage.sv
// Instruction fetch: one outstanding word fetch, buffered results, immediate decode at the head.
module ifu_fetch_stage
    import ifu_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [31:0] i_redirect_pc,
    output logic        o_mem_req_valid,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_req_ready,
    input  logic        i_mem_resp_valid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_resp_err,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_imm,
    output logic [31:0] o_pc,
    output logic        o_exception,
    output logic [3:0]  o_mcause
);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int              EW      = $bits(fetch_entry_t);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q;
    logic         stall_q, stall_d;

    logic          push, pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    fetch_entry_t  push_entry, head;
    logic          inflight, credit, misaligned, req_fire;

    // Credit counts buffered entries plus the fetch in flight so every response has a slot.
    assign inflight   = (state_q != ST_REQ);
    assign occupancy  = {1'b0, fifo_count} + (CW + 1)'(inflight);
    assign credit     = !fifo_full && (occupancy < DEPTH_C);
    assign misaligned = |fetch_pc_q[1:0];

    assign o_mem_req_valid = !i_reset && (state_q == ST_REQ) && credit && !misaligned;
    assign o_mem_addr      = fetch_pc_q;
    assign req_fire        = o_mem_req_valid && i_mem_req_ready;
    assign pop             = !fifo_empty && i_ready;

    // Next-state logic; flush overrides everything, killing any fetch still owed a response.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        stall_d    = stall_q;
        push       = 1'b0;
        push_entry = make_entry(req_pc_q, i_mem_rdata, i_mem_resp_err);
        unique case (state_q)
            ST_REQ: begin
                if (misaligned) begin
                    // Report the bad PC once, then sit here until redirected.
                    if (credit && !stall_q) begin
                        push       = 1'b1;
                        push_entry = '{pc: fetch_pc_q, inst: NOP_INST, exc: 1'b1,
                                       mcause: MCAUSE_INSN_MISALIGNED};
                        stall_d    = 1'b1;
                    end
                end else if (req_fire) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_resp_valid) begin
                    push    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_KILL: begin
                if (i_mem_resp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
        if (i_flush) begin
            push       = 1'b0;
            fetch_pc_d = i_redirect_pc;
            stall_d    = 1'b0;
            state_d    = (req_fire || (inflight && !i_mem_resp_valid)) ? ST_KILL : ST_REQ;
        end
    end

    // State, fetch PC and the PC of the outstanding request.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            stall_q    <= stall_d;
            if (req_fire) req_pc_q <= fetch_pc_q;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_flush),
        .i_push  (push),
        .i_wdata (push_entry),
        .i_pop   (pop),
        .o_rdata (head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    assign o_valid = !fifo_empty;

    // Head fields, forced to zero whenever nothing is buffered.
    always_comb begin
        o_inst      = '0;
        o_pc        = '0;
        o_exception = 1'b0;
        o_mcause    = '0;
        if (!fifo_empty) begin
            o_inst      = head.inst;
            o_pc        = head.pc;
            o_exception = head.exc;
            o_mcause    = head.mcause;
        end
    end

    // Immediate extraction by instruction format.
    always_comb begin
        o_imm = '0;
        case (o_inst[6:2])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:
                o_imm = {{20{o_inst[31]}}, o_inst[31:20]};
            OPC_STORE:
                o_imm = {{20{o_inst[31]}}, o_inst[31:25], o_inst[11:7]};
            OPC_BRANCH:
                o_imm = {{19{o_inst[31]}}, o_inst[31], o_inst[7], o_inst[30:25], o_inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_imm = {o_inst[31:12], 12'b0};
            OPC_JAL:
                o_imm = {{11{o_inst[31]}}, o_inst[31], o_inst[19:12], o_inst[20], o_inst[30:21], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule
